// File: rtl/song_sequencer_if.sv
// Bundle between the song sequencer, its note ROM and the mode multiplexer.
// master: host/ROM side that drives controls and ROM data; slave: the sequencer.
interface song_sequencer_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic              pause;
    logic [1:0]        song_select;
    logic [1:0]        speed_select;
    logic [ADDR_W-1:0] rom_addr;
    logic [10:0]       rom_data;
    logic [3:0]        note_out;
    logic [1:0]        octave_out;
    logic [6:0]        led_out;
    logic [3:0]        num;
    logic [1:0]        num_speed;
    logic              busy;
    logic              done;

    modport master (
        output start, pause, song_select, speed_select, rom_data,
        input  rom_addr, note_out, octave_out, led_out, num, num_speed, busy, done
    );

    modport slave (
        input  start, pause, song_select, speed_select, rom_data,
        output rom_addr, note_out, octave_out, led_out, num, num_speed, busy, done
    );
endinterface

// File: rtl/song_sequencer.sv
// Plays a stored song from a synchronous note ROM: addressing, note timing, gaps, pause, abort.
// Optional macro SONG_SEQUENCER_LOOP_EN: repeat the song forever instead of returning to idle.
module song_sequencer #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_TICK = 12_500_000,
    parameter int unsigned GAP_CYC   = 1_000_000
) (
    input  logic            clk,
    input  logic            reset,
    song_sequencer_if.slave bus
);
    localparam int unsigned UNIT_NRM = (BASE_TICK > 0) ? BASE_TICK : 1;
    localparam int unsigned UNIT_FST = (UNIT_NRM / 2 > 0) ? UNIT_NRM / 2 : 1;
    localparam int unsigned UNIT_SLW = UNIT_NRM * 2;
    localparam int unsigned UNIT_W   = $clog2(UNIT_SLW + 1);
    localparam int unsigned GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
    localparam int unsigned GAP_W    = $clog2(GAP_LAST + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP
    } state_e;

    state_e              state_q, state_d;
    logic [5:0]          index_q, index_d;
    logic [1:0]          song_q, song_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          note_q, note_d;
    logic [3:0]          note_out_q, note_out_d;
    logic [1:0]          oct_q, oct_d;
    logic [6:0]          led_q, led_d;
    logic [3:0]          num_q, num_d;
    logic [1:0]          spd_q, spd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [UNIT_W-1:0]   unit_q, unit_d;
    logic [3:0]          units_q, units_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                song_end;

    logic                rom_end_c;
    logic [1:0]          rom_oct_c;
    logic [3:0]          rom_note_c;
    logic [3:0]          rom_dur_c;
    logic                abort_c;

    assign rom_end_c  = bus.rom_data[10];
    assign rom_oct_c  = bus.rom_data[9:8];
    assign rom_note_c = bus.rom_data[7:4];
    assign rom_dur_c  = bus.rom_data[3:0];
    assign abort_c    = (state_q != S_IDLE) && (bus.song_select != song_q);

    function automatic logic [6:0] led_of(input logic [3:0] n);
        logic [6:0] l;
        l = 7'd0;
        if (n >= 4'd1 && n <= 4'd7) l = 7'd1 << (n - 4'd1);
        return l;
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input logic [1:0] s, input logic [5:0] i);
        return ADDR_W'({s, i});
    endfunction

    // Last value of the per-unit down counter for the given speed code.
    function automatic logic [UNIT_W-1:0] unit_last(input logic [1:0] s);
        logic [UNIT_W-1:0] u;
        case (s)
            2'b01:   u = UNIT_W'(UNIT_FST - 1);
            2'b10:   u = UNIT_W'(UNIT_SLW - 1);
            default: u = UNIT_W'(UNIT_NRM - 1);
        endcase
        return u;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            index_q    <= 6'd0;
            song_q     <= 2'd0;
            addr_q     <= '0;
            note_q     <= 4'd0;
            note_out_q <= 4'd0;
            oct_q      <= 2'd0;
            led_q      <= 7'd0;
            num_q      <= 4'd1;
            spd_q      <= 2'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            unit_q     <= '0;
            units_q    <= 4'd0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            song_q     <= song_d;
            addr_q     <= addr_d;
            note_q     <= note_d;
            note_out_q <= note_out_d;
            oct_q      <= oct_d;
            led_q      <= led_d;
            num_q      <= num_d;
            spd_q      <= spd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            unit_q     <= unit_d;
            units_q    <= units_d;
            gap_q      <= gap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        song_d     = song_q;
        addr_d     = addr_q;
        note_d     = note_q;
        note_out_d = note_out_q;
        oct_d      = oct_q;
        led_d      = led_q;
        num_d      = num_q;
        spd_d      = spd_q;
        done_d     = 1'b0;
        unit_d     = unit_q;
        units_d    = units_q;
        gap_d      = gap_q;
        song_end   = 1'b0;

        case (state_q)
            S_IDLE: begin
                num_d  = 4'(bus.song_select) + 4'd1;
                song_d = bus.song_select;
                if (bus.start) begin
                    state_d = S_FETCH;
                    index_d = 6'd0;
                    addr_d  = addr_of(bus.song_select, 6'd0);
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                if (rom_end_c) begin
                    song_end = 1'b1;
                end else begin
                    note_d     = rom_note_c;
                    oct_d      = rom_oct_c;
                    spd_d      = bus.speed_select;
                    unit_d     = unit_last(bus.speed_select);
                    units_d    = (rom_dur_c == 4'd0) ? 4'd0 : rom_dur_c - 4'd1;
                    note_out_d = bus.pause ? 4'd0 : rom_note_c;
                    led_d      = bus.pause ? 7'd0 : led_of(rom_note_c);
                    state_d    = S_PLAY;
                end
            end
            S_PLAY: begin
                if (bus.pause) begin
                    note_out_d = 4'd0;
                    led_d      = 7'd0;
                end else begin
                    note_out_d = note_q;
                    led_d      = led_of(note_q);
                    if (unit_q == '0) begin
                        if (units_q == 4'd0) begin
                            state_d    = S_GAP;
                            gap_d      = GAP_W'(GAP_LAST);
                            note_out_d = 4'd0;
                            led_d      = 7'd0;
                        end else begin
                            units_d = units_q - 4'd1;
                            unit_d  = unit_last(spd_q);
                        end
                    end else begin
                        unit_d = unit_q - UNIT_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (!bus.pause) begin
                    if (gap_q == '0) begin
                        if (index_q == 6'd63) begin
                            song_end = 1'b1;
                        end else begin
                            index_d = index_q + 6'd1;
                            addr_d  = addr_of(song_q, index_q + 6'd1);
                            state_d = S_FETCH;
                        end
                    end else begin
                        gap_d = gap_q - GAP_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (song_end) begin
            done_d     = 1'b1;
            note_out_d = 4'd0;
            led_d      = 7'd0;
            oct_d      = 2'd0;
            index_d    = 6'd0;
`ifdef SONG_SEQUENCER_LOOP_EN
            state_d    = S_FETCH;
            addr_d     = addr_of(song_q, 6'd0);
`else
            state_d    = S_IDLE;
`endif
        end

        // Song change while busy restarts the new song and overrides any end-of-song event.
        if (abort_c) begin
            state_d    = S_FETCH;
            index_d    = 6'd0;
            addr_d     = addr_of(bus.song_select, 6'd0);
            song_d     = bus.song_select;
            num_d      = 4'(bus.song_select) + 4'd1;
            note_out_d = 4'd0;
            led_d      = 7'd0;
            oct_d      = 2'd0;
            done_d     = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign bus.rom_addr   = addr_q;
    assign bus.note_out   = note_out_q;
    assign bus.octave_out = oct_q;
    assign bus.led_out    = led_q;
    assign bus.num        = num_q;
    assign bus.num_speed  = spd_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with BASE_TICK=4, GAP_CYC=2 and a behavioural synchronous ROM.
module tb_song_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [10:0] rom [256];

`ifdef SONG_SEQUENCER_LOOP_EN
    localparam logic LOOP = 1'b1;
`else
    localparam logic LOOP = 1'b0;
`endif

    song_sequencer_if #(.ADDR_W(8)) bus ();

    song_sequencer #(
        .ADDR_W   (8),
        .BASE_TICK(4),
        .GAP_CYC  (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input int song, input int idx, input logic e, input logic [1:0] o,
                       input logic [3:0] n, input logic [3:0] d);
        rom[song * 64 + idx] = {e, o, n, d};
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_busy_end"}, 32'(bus.busy), 32'(LOOP));
        tick(1);
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    // One-note song: start, verify note fields, measure how long it is held, then the gap and end.
    task automatic run_note(input logic [1:0] song, input logic [1:0] spd, input logic [3:0] note,
                            input logic [1:0] oct, input logic [6:0] led, input int exp_len,
                            input string tag);
        int cnt;
        bus.song_select  = song;
        bus.speed_select = spd;
        bus.start        = 1'b1;
        tick(1);
        bus.start = 1'b0;
        check({tag, "_addr0"}, 32'(bus.rom_addr), 32'({song, 6'd0}));
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_silent_fetch"}, 32'(bus.note_out), 32'd0);
        tick(2);
        check({tag, "_note"}, 32'(bus.note_out), 32'(note));
        check({tag, "_oct"}, 32'(bus.octave_out), 32'(oct));
        check({tag, "_led"}, 32'(bus.led_out), 32'(led));
        check({tag, "_nspd"}, 32'(bus.num_speed), 32'(spd));
        cnt = 0;
        while (bus.note_out == note && cnt < 100) begin
            cnt++;
            tick(1);
        end
        check({tag, "_len"}, 32'(cnt), 32'(exp_len));
        check({tag, "_gap_note"}, 32'(bus.note_out), 32'd0);
        check({tag, "_gap_led"}, 32'(bus.led_out), 32'd0);
        check({tag, "_gap_oct"}, 32'(bus.octave_out), 32'(oct));
        tick(2);
        check({tag, "_addr1"}, 32'(bus.rom_addr), 32'({song, 6'd1}));
        wait_done(tag);
        do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int hi_after;
        int n;
        int amin;
        int amax;
        int addr_done;
        logic busy_done;
        logic seen;
        logic done_early;

        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) rom[i] = 11'd0;
        reset            = 1'b0;
        bus.start        = 1'b0;
        bus.pause        = 1'b0;
        bus.song_select  = 2'd1;
        bus.speed_select = 2'd0;

        put(1, 0, 1'b0, 2'd1, 4'd3, 4'd2);
        put(1, 1, 1'b1, 2'd0, 4'd0, 4'd0);
        put(2, 0, 1'b0, 2'd2, 4'd5, 4'd3);
        put(2, 1, 1'b1, 2'd0, 4'd0, 4'd0);
        put(3, 0, 1'b0, 2'd3, 4'd7, 4'd0);
        put(3, 1, 1'b1, 2'd0, 4'd0, 4'd0);
        put(0, 0, 1'b0, 2'd0, 4'd4, 4'd4);
        put(0, 1, 1'b1, 2'd0, 4'd0, 4'd0);

        tick(2);
        check("rst_addr", 32'(bus.rom_addr), 32'd0);
        check("rst_note", 32'(bus.note_out), 32'd0);
        check("rst_oct", 32'(bus.octave_out), 32'd0);
        check("rst_led", 32'(bus.led_out), 32'd0);
        check("rst_num", 32'(bus.num), 32'd1);
        check("rst_nspd", 32'(bus.num_speed), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        reset = 1'b1;
        tick(1);
        check("idle_num", 32'(bus.num), 32'd2);
        check("idle_busy", 32'(bus.busy), 32'd0);

        run_note(2'd1, 2'd0, 4'd3, 2'd1, 7'b0000100, 8, "basic");
        run_note(2'd2, 2'd0, 4'd5, 2'd2, 7'b0010000, 12, "spd00");
        run_note(2'd2, 2'd1, 4'd5, 2'd2, 7'b0010000, 6, "spd01");
        run_note(2'd2, 2'd2, 4'd5, 2'd2, 7'b0010000, 24, "spd10");
        run_note(2'd3, 2'd0, 4'd7, 2'd3, 7'b1000000, 4, "dur0");

        // Pause raised in PLAY cycle 3 for 5 cycles.
        bus.song_select = 2'd1;
        bus.start       = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(2);
        hi = 0;
        hi_after = 0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (bus.note_out == 4'd3) begin
                hi++;
                if (cyc >= 7) hi_after++;
            end
            if (bus.done === 1'b1) seen = 1'b1;
            if (cyc == 4) check("pause_note", 32'(bus.note_out), 32'd0);
            if (cyc == 4) check("pause_led", 32'(bus.led_out), 32'd0);
            if (cyc == 2) bus.pause = 1'b1;
            if (cyc == 7) bus.pause = 1'b0;
            tick(1);
        end
        check("pause_total", 32'(hi), 32'd8);
        check("pause_resume", 32'(hi_after), 32'd5);
        check("pause_done", 32'(seen), 32'd1);
        do_reset();

        // Song change 0 -> 2 during PLAY, with pause also high.
        bus.song_select = 2'd0;
        bus.start       = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(2);
        check("abort_pre_note", 32'(bus.note_out), 32'd4);
        tick(2);
        bus.song_select = 2'd2;
        bus.pause       = 1'b1;
        tick(1);
        bus.pause = 1'b0;
        check("abort_addr", 32'(bus.rom_addr), 32'd128);
        check("abort_note", 32'(bus.note_out), 32'd0);
        check("abort_num", 32'(bus.num), 32'd3);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd1);
        tick(2);
        check("abort_new_note", 32'(bus.note_out), 32'd5);
        check("abort_new_oct", 32'(bus.octave_out), 32'd2);
        wait_done("abort");
        do_reset();

        // Asynchronous reset in the middle of a note.
        bus.song_select = 2'd1;
        bus.start       = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(3);
        check("mrst_pre_note", 32'(bus.note_out), 32'd3);
        reset = 1'b0;
        #2;
        check("mrst_note", 32'(bus.note_out), 32'd0);
        check("mrst_led", 32'(bus.led_out), 32'd0);
        check("mrst_oct", 32'(bus.octave_out), 32'd0);
        check("mrst_addr", 32'(bus.rom_addr), 32'd0);
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_num", 32'(bus.num), 32'd1);
        tick(1);
        reset = 1'b1;
        tick(1);
        check("mrst_idle_num", 32'(bus.num), 32'd2);
        check("mrst_idle_busy", 32'(bus.busy), 32'd0);

        // 64 words with no end flag.
        for (int i = 0; i < 64; i++) put(1, i, 1'b0, 2'd0, 4'd1, 4'd0);
        bus.song_select = 2'd1;
        bus.start       = 1'b1;
        tick(1);
        bus.start  = 1'b0;
        amin       = 255;
        amax       = 0;
        addr_done  = 0;
        busy_done  = 1'b0;
        seen       = 1'b0;
        done_early = 1'b0;
        n          = 0;
        while (!seen && n < 1500) begin
            if (bus.done === 1'b1) begin
                seen      = 1'b1;
                addr_done = int'(bus.rom_addr);
                busy_done = bus.busy;
            end else begin
                if (int'(bus.rom_addr) < amin) amin = int'(bus.rom_addr);
                if (int'(bus.rom_addr) > amax) amax = int'(bus.rom_addr);
                if (n < 400 && bus.busy !== 1'b1) done_early = 1'b1;
                tick(1);
                n++;
            end
        end
        check("wrap_done", 32'(seen), 32'd1);
        check("wrap_min", 32'(amin), 32'd64);
        check("wrap_max", 32'(amax), 32'd127);
        check("wrap_no_early_end", 32'(done_early), 32'd0);
        check("wrap_addr_at_done", 32'(addr_done), LOOP ? 32'd64 : 32'd127);
        check("wrap_busy_at_done", 32'(busy_done), 32'(LOOP));
        tick(1);
        check("wrap_done_pulse", 32'(bus.done), 32'd0);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Sequences playback of a stored song from a synchronous note ROM and drives the note, octave and LED signals consumed by the auto and learn mode paths.
- Owns ROM addressing, per-note duration timing with speed scaling, articulation gaps, pause and song restart.
- Sits between the song ROM and the mode multiplexer that feeds the tone generator and display.

Parameters:
- ADDR_W, 8: ROM address width; 4 songs x 64 words, song base = song_select*64.
- BASE_TICK, 12_500_000: clock cycles per duration unit at normal speed (125 ms at 100 MHz).
- GAP_CYC, 1_000_000: silent clock cycles inserted after every note.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins playback of the selected song when idle
- pause  in  1  level; freezes playback while high
- song_select  in  2  song index 0..3
- speed_select  in  2  00 normal, 01 fast, 10 slow, 11 normal
- rom_addr  out  ADDR_W  ROM read address
- rom_data  in  11  {end[10], octave[9:8], note[7:4], dur[3:0]}; valid 1 cycle after rom_addr
- note_out  out  4  current note, 0 = silence
- octave_out  out  2  current octave
- led_out  out  7  one-hot note indicator
- num  out  4  displayed song number, song_select+1
- num_speed  out  2  speed currently in effect
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of song

Behaviour:
- Reset (reset=0, asynchronous) forces the following: state IDLE, rom_addr=0, note_out=0, octave_out=0, led_out=0, num=1, num_speed=00, busy=0, done=0, all counters 0.
- States: IDLE, FETCH, LOAD, PLAY, GAP.
- IDLE:
  - num tracks song_select+1 every cycle.
  - start=1 moves to FETCH with index=0.
  - start is ignored in every other state.
- FETCH:
  - Drives rom_addr = {song_select, index[5:0]}.
  - Moves to LOAD next cycle.
- LOAD:
  - Captures rom_data.
  - If end=1, pulses done for 1 cycle, outputs go silent and the block returns to IDLE.
  - Otherwise registers note_out, octave_out, led_out and num_speed (speed_select sampled here).
  - Loads the duration counter and moves to PLAY.
  - Outputs change on the LOAD->PLAY edge, so first-note latency is 2 cycles after start (FETCH, LOAD).
- Duration:
  - unit length L = BASE_TICK for 00/11, BASE_TICK/2 for 01 (integer divide), BASE_TICK*2 for 10.
  - PLAY lasts max(dur,1)*L cycles; dur=0 is treated as 1.
- led_out:
  - bit (note-1) set for note 1..7.
  - all zero for note 0 or note 8..15.
- GAP:
  - note_out=0 and led_out=0 for GAP_CYC cycles; octave_out holds.
  - Then index increments and the block moves to FETCH.
- Index wrap: after index 63 without an end flag, the block pulses done and goes to IDLE. It never reads into the next song.
- Pause:
  - While high in PLAY or GAP, counters freeze and note_out/led_out are forced 0.
  - On release, the remaining time resumes and the stored note is restored the next cycle.
  - Pause in FETCH/LOAD takes effect on entering PLAY.
- song_select change while busy:
  - Abort immediately: index=0, go to FETCH, outputs silent, no done pulse.
  - num updates to the new song.
- speed_select change mid-note takes effect at the next LOAD.
- Simultaneous events:
  - A song_select change wins over an end of note or end of song in the same cycle.
  - pause does not block the abort.

Optional Feature:
- Macro: SONG_SEQUENCER_LOOP_EN
- Defined: on the end flag or index wrap, done still pulses for 1 cycle, then the block re-enters FETCH with index=0 (continuous repeat until reset or abort via song_select change); busy stays high.
- Undefined: the block returns to IDLE as described in Behaviour.

Test Plan:
- Test parameters for all scenarios: BASE_TICK=4, GAP_CYC=2.
- Reset/idle: assert reset=0 mid-PLAY -> all outputs return to reset values at once; after release, num=song_select+1 and busy=0.
- Basic playback: song 1 ROM {note3,oct1,dur2},{end}; start -> rom_addr=64; note_out=3, led_out=0000100, octave_out=1 for 8 cycles; 2 silent cycles; done pulses for 1 cycle; busy falls.
- Speed scaling: same note with dur=3 -> note held 12 cycles at 00, 6 cycles at 01, 24 cycles at 10; num_speed matches; dur=0 -> held 4 cycles.
- Pause: pause=1 for 5 cycles at PLAY cycle 3 of 8 -> note_out=0 during the pause, then 5 more cycles of note; total note-high cycles = 8.
- Abort: change song_select 0->2 during PLAY -> next cycle FETCH with rom_addr=128, no done pulse, num=3.
- Wrap/loop: 64 words with no end flag -> done pulses after word 63. With SONG_SEQUENCER_LOOP_EN defined, rom_addr returns to the song base and busy stays 1.
